// File: rtl/adder_vector_seq.sv
// adder_vector_seq
// ----------------
// A clocked, self-checking sequencer for a pair of 1-bit full-adder stages.
// It drives the adder inputs through all 8 combinations and holds each one
// for a settle window. It then samples both adder responses and compares
// them against a golden full-adder model.
//
// Parameters:
//   SETTLE          cycles each vector is held before it is checked (1..255)
//   ERR_W           width of the saturating mismatch counter
//
// Ports:
//   clk             rising-edge clock
//   rst_n           synchronous active-low reset
//   start           one-cycle request to run the full 8-vector sequence
//   a, b, ci        registered adder inputs (a=vec[0], b=vec[1], ci=vec[2])
//   sum1, co1       response of adder implementation 1
//   sum2, co2       response of adder implementation 2
//   busy            high while a sequence runs
//   done            high from sequence end until the next accepted start/reset
//   pass            valid with done; 1 when no vector mismatched
//   err_count       vectors with any mismatch, saturating at all-ones
//   err1, err2      sticky per-implementation mismatch flags
//   first_err_vec   index of the first mismatching vector
//   first_err_valid first_err_vec holds a captured index
module adder_vector_seq #(
  parameter int SETTLE = 10,
  parameter int ERR_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             a,
  output logic             b,
  output logic             ci,
  input  logic             sum1,
  input  logic             co1,
  input  logic             sum2,
  input  logic             co2,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic             err1,
  output logic             err2,
  output logic [2:0]       first_err_vec,
  output logic             first_err_valid
);

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    CHECK,
    DONE
  } state_t;

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE - 1);

  state_t           state;
  logic [2:0]       vec;
  logic [7:0]       settle_cnt;

  logic             exp_sum;
  logic             exp_co;
  logic             m1;
  logic             m2;
  logic             any_mis;
  logic [2:0]       vec_inc;
  logic [ERR_W-1:0] err_next;

  // Golden model and mismatch detection. The expectation is built from the
  // registered a/b/ci, so it describes exactly what the adders are seeing.
  // err_next is the count after this vector; it is needed in CHECK so that
  // pass can reflect the final vector on the same edge that enters DONE.
  always_comb begin
    exp_sum  = a ^ b ^ ci;
    exp_co   = (a & b) | (a & ci) | (b & ci);
    m1       = (sum1 != exp_sum) | (co1 != exp_co);
    m2       = (sum2 != exp_sum) | (co2 != exp_co);
    any_mis  = m1 | m2;
    vec_inc  = vec + 3'd1;
    err_next = err_count;
    if (any_mis && (err_count != '1)) begin
      err_next = err_count + ERR_W'(1);
    end
  end

  // Sequencer. All outputs are registered here so the adder inputs never
  // glitch and the result flags change only on state transitions.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= IDLE;
      vec             <= 3'd0;
      settle_cnt      <= 8'd0;
      a               <= 1'b0;
      b               <= 1'b0;
      ci              <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      err_count       <= '0;
      err1            <= 1'b0;
      err2            <= 1'b0;
      first_err_vec   <= 3'd0;
      first_err_valid <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state           <= DRIVE;
            vec             <= 3'd0;
            settle_cnt      <= 8'd0;
            {ci, b, a}      <= 3'd0;
            busy            <= 1'b1;
            done            <= 1'b0;
            pass            <= 1'b0;
            err_count       <= '0;
            err1            <= 1'b0;
            err2            <= 1'b0;
            first_err_vec   <= 3'd0;
            first_err_valid <= 1'b0;
          end
        end

        DRIVE: begin
          if (settle_cnt == SETTLE_LAST) begin
            settle_cnt <= 8'd0;
            state      <= CHECK;
          end else begin
            settle_cnt <= settle_cnt + 8'd1;
          end
        end

        CHECK: begin
          err1      <= err1 | m1;
          err2      <= err2 | m2;
          err_count <= err_next;
          // Only the first failing vector is recorded.
          if (any_mis && !first_err_valid) begin
            first_err_vec   <= vec;
            first_err_valid <= 1'b1;
          end
          if (vec == 3'd7) begin
            state      <= DONE;
            busy       <= 1'b0;
            done       <= 1'b1;
            pass       <= (err_next == '0);
            {ci, b, a} <= 3'd0;
          end else begin
            state      <= DRIVE;
            vec        <= vec_inc;
            {ci, b, a} <= vec_inc;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_vector_seq.sv
// tb_adder_vector_seq
// -------------------
// Scoreboard bench for adder_vector_seq. Two sequencer instances are used:
// dut_a with the default SETTLE=10/ERR_W=4 and dut_b with SETTLE=3/ERR_W=2.
// Behavioural adders with selectable faults answer each sequencer. The
// expected end-of-run results are queued when a run is issued. A monitor
// pops and compares them when done rises.
module tb_adder_vector_seq;

  typedef struct {
    logic [3:0] ec;
    logic       e1;
    logic       e2;
    logic [2:0] fev;
    logic       fv;
    logic       pass;
    int         busy_cycles;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start_a;
  logic       start_b;

  logic       a_a, b_a, ci_a, s1_a, c1_a, s2_a, c2_a;
  logic       busy_a, done_a, pass_a, e1_a, e2_a, fv_a;
  logic [3:0] ec_a;
  logic [2:0] fev_a;

  logic       a_b, b_b, ci_b, s1_b, c1_b, s2_b, c2_b;
  logic       busy_b, done_b, pass_b, e1_b, e2_b, fv_b;
  logic [1:0] ec_b;
  logic [2:0] fev_b;

  // 0: both adders correct, 1: adder 2 carry stuck at 0, 2: both sums inverted
  int fault = 0;
  bit wave_en = 1'b0;

  int checks = 0;
  int failures = 0;

  exp_t q_a[$];
  exp_t q_b[$];

  int   cnt_a = 0;
  int   cnt_b = 0;
  logic done_a_q = 1'b0;
  logic done_b_q = 1'b0;

  // Behavioural adder pair, returned as {sum1, co1, sum2, co2}
  function automatic logic [3:0] adders(input logic x, input logic y,
                                        input logic z, input int f);
    logic s;
    logic c;
    s = x ^ y ^ z;
    c = (x & y) | (x & z) | (y & z);
    case (f)
      1:       return {s, c, s, 1'b0};
      2:       return {~s, c, ~s, c};
      default: return {s, c, s, c};
    endcase
  endfunction

  assign {s1_a, c1_a, s2_a, c2_a} = adders(a_a, b_a, ci_a, fault);
  assign {s1_b, c1_b, s2_b, c2_b} = adders(a_b, b_b, ci_b, fault);

  adder_vector_seq dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a),
    .a(a_a), .b(b_a), .ci(ci_a),
    .sum1(s1_a), .co1(c1_a), .sum2(s2_a), .co2(c2_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(ec_a),
    .err1(e1_a), .err2(e2_a), .first_err_vec(fev_a), .first_err_valid(fv_a)
  );

  adder_vector_seq #(.SETTLE(3), .ERR_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b),
    .a(a_b), .b(b_b), .ci(ci_b),
    .sum1(s1_b), .co1(c1_b), .sum2(s2_b), .co2(c2_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(ec_b),
    .err1(e1_b), .err2(e2_b), .first_err_vec(fev_b), .first_err_valid(fv_b)
  );

  // Single comparison point: every check goes through here
  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compareResult(input string tag, input exp_t e, input int busy_seen,
                               input logic [3:0] ec, input logic e1, input logic e2,
                               input logic [2:0] fev, input logic fv, input logic ps);
    checkOutput({tag, "_busy_cycles"}, busy_seen, e.busy_cycles);
    checkOutput({tag, "_err_count"}, 32'(ec), 32'(e.ec));
    checkOutput({tag, "_err1"}, 32'(e1), 32'(e.e1));
    checkOutput({tag, "_err2"}, 32'(e2), 32'(e.e2));
    checkOutput({tag, "_first_err_valid"}, 32'(fv), 32'(e.fv));
    if (e.fv) checkOutput({tag, "_first_err_vec"}, 32'(fev), 32'(e.fev));
    checkOutput({tag, "_pass"}, 32'(ps), 32'(e.pass));
  endtask

  // Monitor: counts busy cycles and walks the stimulus waveform. On each
  // rising done it pops the queued expectation and compares the results.
  always @(negedge clk) begin
    if (rst_n !== 1'b1) begin
      cnt_a = 0;
      cnt_b = 0;
    end else begin
      if (busy_a) cnt_a++;
      if (busy_b) begin
        if (wave_en) checkOutput("wave_abc_b", 32'({ci_b, b_b, a_b}), 32'(cnt_b / 4));
        cnt_b++;
      end
      if (done_a && !done_a_q) begin
        if (q_a.size() == 0) begin
          checkOutput("dut_a_unexpected_done", 32'd1, 32'd0);
        end else begin
          compareResult("dut_a", q_a.pop_front(), cnt_a, ec_a, e1_a, e2_a, fev_a, fv_a, pass_a);
          checkOutput("dut_a_abc_idle", 32'({a_a, b_a, ci_a}), 32'd0);
        end
        cnt_a = 0;
      end
      if (done_b && !done_b_q) begin
        if (q_b.size() == 0) begin
          checkOutput("dut_b_unexpected_done", 32'd1, 32'd0);
        end else begin
          compareResult("dut_b", q_b.pop_front(), cnt_b, {2'b00, ec_b}, e1_b, e2_b,
                        fev_b, fv_b, pass_b);
          checkOutput("dut_b_abc_idle", 32'({a_b, b_b, ci_b}), 32'd0);
        end
        cnt_b = 0;
      end
    end
    done_a_q = done_a;
    done_b_q = done_b;
  end

  // Issue one run: select the fault, optionally queue the expectation and
  // pulse start for one cycle. Returns on the negedge after the start edge.
  task automatic applyStimulus(input bit on_b, input int f, input bit push, input exp_t e);
    @(negedge clk);
    fault = f;
    if (push) begin
      if (on_b) q_b.push_back(e);
      else      q_a.push_back(e);
    end
    if (on_b) start_b = 1'b1;
    else      start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic waitDone(input bit on_b, input string name);
    int n;
    n = 0;
    while (((on_b ? done_b : done_a) !== 1'b1) && (n < 300)) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) checkOutput({name, "_timeout"}, 32'd1, 32'd0);
    @(negedge clk);
  endtask

  task automatic waitVecA(input logic [2:0] v, input string name);
    int n;
    n = 0;
    while (({ci_a, b_a, a_a} !== v) && (n < 300)) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) checkOutput({name, "_timeout"}, 32'd1, 32'd0);
  endtask

  exp_t e;

  initial begin
    rst_n   = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_dut_a", 32'({a_a, b_a, ci_a, busy_a, done_a, pass_a, ec_a,
                                    e1_a, e2_a, fev_a, fv_a}), 32'd0);
    checkOutput("reset_dut_b", 32'({a_b, b_b, ci_b, busy_b, done_b, pass_b, ec_b,
                                    e1_b, e2_b, fev_b, fv_b}), 32'd0);
    rst_n = 1'b1;

    // Both adders correct, SETTLE=10: 88 busy cycles, clean pass
    e = '{ec: 4'd0, e1: 1'b0, e2: 1'b0, fev: 3'd0, fv: 1'b0, pass: 1'b1, busy_cycles: 88};
    applyStimulus(1'b0, 0, 1'b1, e);
    checkOutput("start_busy_a", 32'(busy_a), 32'd1);
    waitDone(1'b0, "run_clean_a");

    // Adder 2 carry stuck at 0: vectors 3,5,6,7 fail
    e = '{ec: 4'd4, e1: 1'b0, e2: 1'b1, fev: 3'd3, fv: 1'b1, pass: 1'b0, busy_cycles: 88};
    applyStimulus(1'b0, 1, 1'b1, e);
    waitDone(1'b0, "run_co_stuck_a");

    // Start from DONE clears results on the next cycle. A start re-pulsed at
    // vector 2 is ignored, so the run keeps its original 88-cycle length.
    e = '{ec: 4'd0, e1: 1'b0, e2: 1'b0, fev: 3'd0, fv: 1'b0, pass: 1'b1, busy_cycles: 88};
    applyStimulus(1'b0, 0, 1'b1, e);
    checkOutput("restart_cleared", 32'({busy_a, done_a, pass_a, ec_a, e1_a, e2_a, fv_a}),
                32'({1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0}));
    waitVecA(3'd2, "wait_vec2");
    applyStimulus(1'b0, 0, 1'b0, e);
    checkOutput("repulse_still_busy", 32'(busy_a), 32'd1);
    waitDone(1'b0, "run_repulse_a");

    // Reset for one cycle at vector 4 aborts the run without a done
    applyStimulus(1'b0, 0, 1'b0, e);
    waitVecA(3'd4, "wait_vec4");
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("midrun_reset_a", 32'({a_a, b_a, ci_a, busy_a, done_a, pass_a, ec_a,
                                       e1_a, e2_a, fev_a, fv_a}), 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("no_done_after_abort", 32'({busy_a, done_a}), 32'd0);

    // Full run after the abort starts again from vector 0
    e = '{ec: 4'd0, e1: 1'b0, e2: 1'b0, fev: 3'd0, fv: 1'b0, pass: 1'b1, busy_cycles: 88};
    applyStimulus(1'b0, 0, 1'b1, e);
    checkOutput("after_abort_vec0", 32'({ci_a, b_a, a_a}), 32'd0);
    waitDone(1'b0, "run_after_abort_a");

    // ERR_W=2, both sums inverted: every vector fails, counter saturates at 3
    e = '{ec: 4'd3, e1: 1'b1, e2: 1'b1, fev: 3'd0, fv: 1'b1, pass: 1'b0, busy_cycles: 32};
    applyStimulus(1'b1, 2, 1'b1, e);
    waitDone(1'b1, "run_saturate_b");

    // SETTLE=3 waveform: each vector held 4 cycles in increasing order
    wave_en = 1'b1;
    e = '{ec: 4'd0, e1: 1'b0, e2: 1'b0, fev: 3'd0, fv: 1'b0, pass: 1'b1, busy_cycles: 32};
    applyStimulus(1'b1, 0, 1'b1, e);
    waitDone(1'b1, "run_wave_b");
    wave_en = 1'b0;

    checkOutput("queue_a_drained", q_a.size(), 32'd0);
    checkOutput("queue_b_drained", q_b.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
